// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port image memory between two requesters.
// Requester 0 is the processing core and requester 1 is the image loader/DMA.
// Grants alternate round-robin. Each granted access runs through a fixed
// IDLE -> ISSUE -> RESP sequence, so at most one access is in flight.
// Out-of-range addresses get an error response and never reach the memory.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   reqN_valid/_write    request pending / 1 = write, 0 = read
//   reqN_addr/_wdata     word address / write data
//   reqN_ready           request accepted this cycle (combinational, IDLE only)
//   rspN_valid           one-cycle response pulse, two cycles after ready
//   rspN_rdata/_err      read data or echoed write data / out-of-range flag
//   mem_address          memory address (forced to 0 for out-of-range accesses)
//   mem_inputData        memory write data
//   mem_writeEnable      memory write strobe, high only in ISSUE
//   mem_out              memory read data (registered read, echoes writes)

module mem_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MEM_DEPTH = 49152
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_inputData,
    output logic              mem_writeEnable,
    input  logic [DATA_W-1:0] mem_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e            state_q,            state_d;
    logic              last_grant_q,       last_grant_d;
    logic              grant_q,            grant_d;
    logic              err_q,              err_d;
    logic [ADDR_W-1:0] mem_address_q,      mem_address_d;
    logic [DATA_W-1:0] mem_input_data_q,   mem_input_data_d;
    logic              mem_write_enable_q, mem_write_enable_d;

    logic              arb_any;
    logic              arb_sel;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;
    logic              accept;
    logic              rsp_fire;
    logic [DATA_W-1:0] rsp_data;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    always_comb begin
        arb_any      = req0_valid | req1_valid;
        arb_sel      = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        sel_write    = arb_sel ? req1_write : req0_write;
        sel_addr     = arb_sel ? req1_addr  : req0_addr;
        sel_wdata    = arb_sel ? req1_wdata : req0_wdata;
        sel_in_range = (32'(sel_addr) < MEM_DEPTH);
        // Accepting is masked during reset so no handshake completes then.
        accept       = rst_n & arb_any & (state_q == ST_IDLE);
    end

    // Next-state and capture of the accepted request.
    always_comb begin
        state_d            = state_q;
        last_grant_d       = last_grant_q;
        grant_d            = grant_q;
        err_d              = err_q;
        mem_address_d      = mem_address_q;
        mem_input_data_d   = mem_input_data_q;
        mem_write_enable_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d            = ST_ISSUE;
                    last_grant_d       = arb_sel;
                    grant_d            = arb_sel;
                    err_d              = ~sel_in_range;
                    // Out-of-range accesses park the address at 0 so the
                    // array is never indexed past its end.
                    mem_address_d      = sel_in_range ? sel_addr : '0;
                    mem_input_data_d   = sel_wdata;
                    mem_write_enable_d = sel_write & sel_in_range;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and capture registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q            <= ST_IDLE;
            last_grant_q       <= 1'b1;
            grant_q            <= 1'b0;
            err_q              <= 1'b0;
            mem_address_q      <= '0;
            mem_input_data_q   <= '0;
            mem_write_enable_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            last_grant_q       <= last_grant_d;
            grant_q            <= grant_d;
            err_q              <= err_d;
            mem_address_q      <= mem_address_d;
            mem_input_data_q   <= mem_input_data_d;
            mem_write_enable_q <= mem_write_enable_d;
        end
    end

    // Handshake and response steering; read data arrives from the memory in RESP.
    always_comb begin
        req0_ready = accept & ~arb_sel;
        req1_ready = accept &  arb_sel;

        rsp_fire   = rst_n & (state_q == ST_RESP);
        rsp_data   = err_q ? '0 : mem_out;

        rsp0_valid = rsp_fire & ~grant_q;
        rsp0_err   = rsp0_valid & err_q;
        rsp0_rdata = rsp0_valid ? rsp_data : '0;

        rsp1_valid = rsp_fire & grant_q;
        rsp1_err   = rsp1_valid & err_q;
        rsp1_rdata = rsp1_valid ? rsp_data : '0;
    end

    assign mem_address     = mem_address_q;
    assign mem_inputData   = mem_input_data_q;
    assign mem_writeEnable = mem_write_enable_q;

endmodule
